// File: rtl/frame_capture_buffer.sv
// frame_capture_buffer: captures a FRM_W x FRM_H window of a pixel stream into
// an on-chip buffer, then reads it back over an Avalon-MM slave.
//
// Ports:
//   clk, reset_n          system clock, synchronous active-low reset
//   addr, rd_en, wr_en    Avalon-MM register select and strobes
//   writedata, readdata   Avalon-MM data (read latency 1)
//   pix_valid, pix_data   incoming pixel strobe and value
//   pix_x, pix_y          screen coordinates of the incoming pixel
//   frame_start           one-cycle pulse at the start of each video frame
//   done_irq              high while a completed frame is held
//
// Registers: 0 CTRL (W: bit0 ARM, bit1 ABORT), 1 STATUS ([1:0] state,
// [31:16] frame count), 2 PTR (R/W buffer index), 3 DATA (R, auto-advance).
//
// Build option: define FCB_MCU_ORDER_EN to advance PTR in 8x8 block order
// instead of linearly (FRM_W and FRM_H must then be multiples of 8).
module frame_capture_buffer #(
    parameter int FRM_W = 224,
    parameter int FRM_H = 224,
    parameter int ORG_X = 208,
    parameter int ORG_Y = 128,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       addr,
    input  logic             rd_en,
    input  logic             wr_en,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    input  logic [10:0]      pix_x,
    input  logic [10:0]      pix_y,
    input  logic             frame_start,
    output logic             done_irq
);
    localparam int DEPTH = FRM_W * FRM_H;
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [31:0]       ptr_q, ptr_d, ptr_adv;
    logic [31:0]       reg_rd_q, reg_rd_d;
    logic              data_sel_q;
    logic [PIX_W-1:0]  mem_rd_q;
    logic [PIX_W-1:0]  mem [DEPTH];

    logic [11:0]       dx, dy;
    logic              in_win, capturing, pix_we, last_pix;
    logic              ctrl_wr, arm, abort, data_ok;
    logic [AW-1:0]     wr_idx, rd_idx;

    // Offsets wrap to large values for pixels left of / above the window,
    // so a single unsigned compare per axis covers both window edges.
    assign dx = {1'b0, pix_x} - 12'(ORG_X);
    assign dy = {1'b0, pix_y} - 12'(ORG_Y);
    assign in_win = (dx < 12'(FRM_W)) && (dy < 12'(FRM_H));
    assign wr_idx = AW'(32'(FRM_W) * 32'(dy) + 32'(dx));

    // Pixels are accepted on the very edge that moves ARMED into CAPTURE.
    assign capturing = (state_q == CAPTURE) || (state_q == ARMED && frame_start);
    assign pix_we = capturing && pix_valid && in_win;
    assign last_pix = pix_we && dx == 12'(FRM_W - 1) && dy == 12'(FRM_H - 1);

    assign ctrl_wr = wr_en && addr == 2'd0;
    assign arm = ctrl_wr && writedata[0];
    assign abort = ctrl_wr && writedata[1];
    assign data_ok = rd_en && addr == 2'd3 && state_q == DONE && ptr_q < 32'(DEPTH);
    assign rd_idx = ptr_q[AW-1:0];

`ifdef FCB_MCU_ORDER_EN
    if (FRM_W % 8 != 0 || FRM_H % 8 != 0) begin : g_bad_geometry
        $error("frame_capture_buffer: FRM_W and FRM_H must be multiples of 8 for block order");
    end

    logic [31:0] px, py, nx, ny;

    // Step through the window 8x8 block by block: raster inside a block,
    // then the next block to the right, then the next block row.
    always_comb begin
        px = ptr_q % 32'(FRM_W);
        py = ptr_q / 32'(FRM_W);
        nx = px[2:0] != 3'd7 ? px + 32'd1 :
             py[2:0] != 3'd7 ? px - 32'd7 :
             px != 32'(FRM_W - 1) ? px + 32'd1 : 32'd0;
        ny = px[2:0] != 3'd7 ? py :
             py[2:0] != 3'd7 ? py + 32'd1 :
             px != 32'(FRM_W - 1) ? py - 32'd7 : py + 32'd1;
        ptr_adv = ny * 32'(FRM_W) + nx;
    end
`else
    assign ptr_adv = ptr_q + 32'd1;
`endif

    always_comb begin
        state_d = state_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            IDLE, DONE: state_d = arm ? ARMED : state_q;
            ARMED:      state_d = frame_start ? CAPTURE : ARMED;
            default:    state_d = state_q;
        endcase
        if (last_pix) begin
            state_d = DONE;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        if (abort) begin
            state_d = IDLE;
            frame_cnt_d = frame_cnt_q;
        end
    end

    always_comb begin
        ptr_d = (wr_en && addr == 2'd2) ? writedata : data_ok ? ptr_adv : ptr_q;
        reg_rd_d = !rd_en ? 32'd0 :
                   addr == 2'd1 ? {frame_cnt_q, 14'd0, state_q} :
                   addr == 2'd2 ? ptr_q : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            frame_cnt_q <= 16'd0;
            ptr_q <= 32'd0;
            reg_rd_q <= 32'd0;
            data_sel_q <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_cnt_q <= frame_cnt_d;
            ptr_q <= ptr_d;
            reg_rd_q <= reg_rd_d;
            data_sel_q <= data_ok;
        end
    end

    // Buffer: one write port, one synchronous read port, no reset.
    always_ff @(posedge clk) begin
        if (pix_we) mem[wr_idx] <= pix_data;
        mem_rd_q <= mem[rd_idx];
    end

    assign readdata = data_sel_q ? 32'(mem_rd_q) : reg_rd_q;
    assign done_irq = state_q == DONE;
endmodule

// File: tb/tb_frame_capture_buffer.sv
module tb_frame_capture_buffer;
    localparam int W = 16;
    localparam int H = 16;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_data = 8'd0;
    logic [10:0] pix_x = 11'd0;
    logic [10:0] pix_y = 11'd0;
    logic        frame_start = 1'b0;
    logic        done_irq;

    int checks = 0;
    int errors = 0;

    // Reference model: state number, frame count, pointer, buffer image, and
    // the readout order as a list of linear indices.
    int m_state, m_cnt, m_ptr;
    int m_buf[N];
    int order[N];
    int pos[N];

    always #5 clk = ~clk;

    frame_capture_buffer #(.FRM_W(W), .FRM_H(H), .ORG_X(0), .ORG_Y(0), .PIX_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
        .writedata(writedata), .readdata(readdata), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .done_irq(done_irq)
    );

    function automatic void build_order();
        int k = 0;
`ifdef FCB_MCU_ORDER_EN
        for (int by = 0; by < H / 8; by++)
            for (int bx = 0; bx < W / 8; bx++)
                for (int y = 0; y < 8; y++)
                    for (int x = 0; x < 8; x++) begin
                        order[k] = (by * 8 + y) * W + bx * 8 + x;
                        k++;
                    end
`else
        for (int i = 0; i < N; i++) begin
            order[k] = i;
            k++;
        end
`endif
        for (int i = 0; i < N; i++) pos[order[i]] = i;
    endfunction

    function automatic int m_next(input int p);
        return (pos[p] == N - 1) ? N : order[pos[p] + 1];
    endfunction

    function automatic logic [31:0] m_status();
        return {m_cnt[15:0], 14'd0, m_state[1:0]};
    endfunction

    function automatic void m_reset();
        m_state = 0;
        m_cnt = 0;
        m_ptr = 0;
    endfunction

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        addr = a;
        writedata = d;
        wr_en = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        if (a == 2'd0) begin
            if (d[1]) m_state = 0;
            else if (d[0] && (m_state == 0 || m_state == 3)) m_state = 1;
        end
        if (a == 2'd2) m_ptr = int'(d);
    endtask

    // Returns the DUT's answer and the model's prediction for one register read.
    task automatic bus_read(input logic [1:0] a, output logic [31:0] got, output logic [31:0] exp);
        exp = 32'd0;
        if (a == 2'd1) exp = m_status();
        if (a == 2'd2) exp = 32'(m_ptr);
        if (a == 2'd3 && m_state == 3 && m_ptr < N) begin
            exp = 32'(m_buf[m_ptr]);
            m_ptr = m_next(m_ptr);
        end
        addr = a;
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        got = readdata;
    endtask

    task automatic send_pix(input int x, input int y, input int v);
        pix_x = 11'(x);
        pix_y = 11'(y);
        pix_data = 8'(v);
        pix_valid = 1'b1;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        if (m_state == 2 && x < W && y < H) begin
            m_buf[y * W + x] = v;
            if (x == W - 1 && y == H - 1) begin
                m_state = 3;
                m_cnt = (m_cnt + 1) & 16'hffff;
            end
        end
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        if (m_state == 1 || m_state == 2) m_state = 2;
    endtask

    // Idle cycle or a pixel outside the window.
    task automatic noise();
        if ($urandom_range(0, 1) == 0) begin
            @(posedge clk);
            #1;
        end else if ($urandom_range(0, 1) == 0)
            send_pix(W + int'($urandom_range(0, 2047 - W)), int'($urandom_range(0, 2047)), int'($urandom_range(0, 255)));
        else
            send_pix(int'($urandom_range(0, 2047)), H + int'($urandom_range(0, 2047 - H)), int'($urandom_range(0, 255)));
    endtask

    task automatic test_reset();
        logic [31:0] got, exp;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_reset();
        checks++;
        if (done_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %0b want 0", done_irq); end
        checks++;
        if (readdata !== 32'd0) begin errors++; $display("FAIL reset_readdata got %h want 0", readdata); end
        bus_read(2'd1, got, exp);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_status got %h want %h", got, exp); end
        bus_read(2'd2, got, exp);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_ptr got %h want %h", got, exp); end
        bus_read(2'd3, got, exp);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_data got %h want %h", got, exp); end
    endtask

    task automatic test_capture();
        logic [31:0] got, exp;
        bus_write(2'd0, 32'd1);
        bus_read(2'd1, got, exp);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL arm_status got %h want %h", got, exp); end
        pulse_fs();
        bus_read(2'd1, got, exp);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL capture_status got %h want %h", got, exp); end
        for (int i = 0; i < N; i++) begin
            if (i == 50) begin
                bus_write(2'd0, 32'd1);
                bus_read(2'd1, got, exp);
                checks++;
                if (got !== exp) begin errors++; $display("FAIL arm_in_capture got %h want %h", got, exp); end
            end
            if (i == 100) begin
                send_pix(W, 0, 8'hee);
                send_pix(0, H, 8'hdd);
                bus_read(2'd1, got, exp);
                checks++;
                if (got !== exp) begin errors++; $display("FAIL outside_window_status got %h want %h", got, exp); end
            end
            if ($urandom_range(0, 3) == 0) noise();
            send_pix(i % W, i / W, (i % W) + W * (i / W));
        end
        checks++;
        if (done_irq !== 1'b1) begin errors++; $display("FAIL done_irq got %0b want 1", done_irq); end
        bus_read(2'd1, got, exp);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL done_status got %h want %h", got, exp); end
    endtask

    task automatic test_readout();
        logic [31:0] got, exp;
        bus_write(2'd2, 32'd0);
        for (int i = 0; i < N; i++) begin
            bus_read(2'd3, got, exp);
            checks++;
            if (got !== exp) begin errors++; $display("FAIL readout[%0d] got %h want %h", i, got, exp); end
        end
        @(posedge clk);
        #1;
        checks++;
        if (readdata !== 32'd0) begin errors++; $display("FAIL idle_readdata got %h want 0", readdata); end
    endtask

    task automatic test_ptr_bounds();
        logic [31:0] got, exp;
        int starts[3] = '{N, N - 1, 7};
        foreach (starts[k]) begin
            bus_write(2'd2, 32'(starts[k]));
            bus_read(2'd3, got, exp);
            checks++;
            if (got !== exp) begin errors++; $display("FAIL bound_data@%0d got %h want %h", starts[k], got, exp); end
            bus_read(2'd2, got, exp);
            checks++;
            if (got !== exp) begin errors++; $display("FAIL bound_ptr@%0d got %h want %h", starts[k], got, exp); end
        end
    endtask

    task automatic test_restart();
        logic [31:0] got, exp;
        int part = int'($urandom_range(40, 150));
        bus_write(2'd0, 32'd1);
        bus_read(2'd1, got, exp);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL rearm_status got %h want %h", got, exp); end
        pulse_fs();
        for (int i = 0; i < part; i++) send_pix(i % W, i / W, int'($urandom_range(0, 255)));
        pulse_fs();
        bus_read(2'd1, got, exp);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL restart_status got %h want %h", got, exp); end
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 4) == 0) noise();
            send_pix(i % W, i / W, int'($urandom_range(0, 255)));
        end
        bus_read(2'd1, got, exp);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL restart_done got %h want %h", got, exp); end
        bus_write(2'd2, 32'($urandom_range(0, N - 1)));
        for (int i = 0; i < 24; i++) begin
            bus_read(2'd3, got, exp);
            checks++;
            if (got !== exp) begin errors++; $display("FAIL random_read[%0d] got %h want %h", i, got, exp); end
        end
        bus_read(2'd2, got, exp);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL random_ptr got %h want %h", got, exp); end
    endtask

    task automatic test_abort();
        logic [31:0] got, exp;
        bus_write(2'd0, 32'd1);
        bus_write(2'd0, 32'd1);
        bus_read(2'd1, got, exp);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL arm_twice got %h want %h", got, exp); end
        pulse_fs();
        for (int i = 0; i < 20; i++) send_pix(i % W, i / W, int'($urandom_range(0, 255)));
        bus_write(2'd2, 32'd5);
        bus_read(2'd3, got, exp);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL capture_data got %h want %h", got, exp); end
        bus_read(2'd2, got, exp);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL capture_ptr got %h want %h", got, exp); end
        bus_write(2'd0, 32'd3);
        bus_read(2'd1, got, exp);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL abort_status got %h want %h", got, exp); end
        checks++;
        if (done_irq !== 1'b0) begin errors++; $display("FAIL abort_irq got %0b want 0", done_irq); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got, exp;
        bus_write(2'd0, 32'd1);
        pulse_fs();
        for (int i = 0; i < 100; i++) send_pix(i % W, i / W, i);
        reset_n = 1'b0;
        send_pix(100 % W, 100 / W, 100);
        reset_n = 1'b1;
        m_reset();
        for (int i = 101; i < N; i++) send_pix(i % W, i / W, i);
        bus_read(2'd1, got, exp);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL midreset_status got %h want %h", got, exp); end
        bus_read(2'd3, got, exp);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL midreset_data got %h want %h", got, exp); end
        checks++;
        if (done_irq !== 1'b0) begin errors++; $display("FAIL midreset_irq got %0b want 0", done_irq); end
    endtask

    initial begin
        build_order();
        m_reset();
        test_reset();
        test_capture();
        test_readout();
        test_ptr_bounds();
        test_restart();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_capture_buffer.md
FRAME_CAPTURE_BUFFER -- requirements
Module: frame_capture_buffer

Interface
REQ-001 FRM_W, 224, capture window width in pixels.
REQ-002 FRM_H, 224, capture window height in pixels.
REQ-003 ORG_X, 208, screen X of window top-left pixel.
REQ-004 ORG_Y, 128, screen Y of window top-left pixel.
REQ-005 PIX_W, 8, pixel width in bits (1..16).
REQ-006 clk  in  1  system clock; all logic on rising edge.
REQ-007 reset_n  in  1  reset, synchronous, active-low.
REQ-008 addr  in  2  Avalon-MM register select.
REQ-009 rd_en  in  1  Avalon read strobe.
REQ-010 wr_en  in  1  Avalon write strobe.
REQ-011 writedata  in  32  Avalon write data.
REQ-012 readdata  out  32  Avalon read data, fixed read latency 1.
REQ-013 pix_valid  in  1  pixel strobe, already synchronous to clk.
REQ-014 pix_data  in  PIX_W  pixel value.
REQ-015 pix_x, pix_y  in  11 each  screen coordinates of pix_data.
REQ-016 frame_start  in  1  one-cycle pulse at start of each video frame.
REQ-017 done_irq  out  1  high while state is DONE.

Function
REQ-018 Registers: addr0 CTRL (W: bit0 ARM, bit1 ABORT; R: 0); addr1 STATUS (R: [1:0] state, [31:16] frame_cnt); addr2 PTR (R/W, 32 bit); addr3 DATA (R only).
REQ-019 States: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
REQ-020 IDLE or DONE + ARM -> ARMED; ARMED + frame_start -> CAPTURE (same edge begins accepting pixels).
REQ-021 CAPTURE: pix_valid with ORG_X<=pix_x<ORG_X+FRM_W and ORG_Y<=pix_y<ORG_Y+FRM_H writes pix_data to buffer[FRM_W*(pix_y-ORG_Y)+(pix_x-ORG_X)]; other pixels ignored; no writes in other states.
REQ-022 CAPTURE -> DONE on the cycle the pixel at (ORG_X+FRM_W-1, ORG_Y+FRM_H-1) is written; frame_cnt increments (mod 2^16) on that edge.
REQ-023 frame_start during CAPTURE restarts capture (state stays CAPTURE, prior partial data overwritten).
REQ-024 ABORT from any state -> IDLE; ABORT and ARM in same write: ABORT wins.
REQ-025 ARM while ARMED or CAPTURE: ignored.
REQ-026 DATA read: readdata = zero-extended buffer[PTR] one cycle after rd_en when state=DONE and PTR<FRM_W*FRM_H; otherwise 0.
REQ-027 DATA read with valid return advances PTR by one index on the rd_en edge; out-of-range or non-DONE reads do not advance PTR.
REQ-028 PTR write and DATA read on same cycle: write wins, read returns data at old PTR.
REQ-029 Other register reads return value one cycle after rd_en; readdata=0 in the cycle after no rd_en.
REQ-030 Buffer is FRM_W*FRM_H x PIX_W, single write port, single synchronous read port.

Reset
REQ-031 reset_n low: state=IDLE, PTR=0, frame_cnt=0, readdata=0, done_irq=0; buffer contents undefined.
REQ-032 Reset mid-CAPTURE abandons frame; no DONE, no frame_cnt increment.

Configuration
REQ-033 FCB_MCU_ORDER_EN defined: PTR advance follows 8x8 block order (raster within block, blocks raster-ordered), PTR holds linear index; FRM_W, FRM_H must be multiples of 8 (elaboration error otherwise).
REQ-034 FCB_MCU_ORDER_EN undefined: PTR advances linearly (+1).

Verification
REQ-035 FRM_W=FRM_H=16, ORG=(0,0): ARM, frame_start, stream 256 pixels value=x+16*y -> state DONE, done_irq=1, frame_cnt=1.
REQ-036 After REQ-035, PTR=0, 256 DATA reads -> values 0..255 in order (linear); with FCB_MCU_ORDER_EN reads 0-7 then 16-23 ... 8th value 7, 9th value 16.
REQ-037 PTR=256 then DATA read -> readdata 0, PTR stays 256.
REQ-038 Pixels at (16,0) and (0,16) during CAPTURE -> buffer unchanged, state stays CAPTURE.
REQ-039 CTRL write 0x3 during CAPTURE -> state IDLE, frame_cnt unchanged.
REQ-040 reset_n low for one cycle at pixel 100 of capture -> STATUS reads 0, DATA read returns 0.
